adc_sar_scan_core: RTL
======================

# adc_sar_scan_core

Parametrised successor to the SAR-ADC core logic. It runs a binary successive-approximation conversion of configurable resolution across a scanned set of input channels. Each channel's result is the sum of 2^osr conversions, delivered one channel at a time over a valid/ready result port. It sits between the comparator/cap-matrix analog front end and the bus-side register or FIFO logic.

## Interface
Parameters:
- RES_BITS, 12: conversion resolution in bits (≥2).
- CH_CNT, 4: number of analog channels (≥1); CH_W = max(1, clog2(CH_CNT)).
- OSR_MAX_LOG2, 4: maximum oversampling exponent; OSR_W = clog2(OSR_MAX_LOG2+1).
- SAMPLE_CYCLES, 2: sampling-phase length (≥1).
- SETTLE_CYCLES, 4: mux-settle length after a channel change (≥1; used only with the macro).

Ports:
- clk_dig_in  in  1  conversion clock.
- rst_in  in  1  reset, synchronous, active-high.
- start_in  in  1  start a scan; honoured only in IDLE.
- continuous_in  in  1  rescan after the last enabled channel instead of returning to IDLE.
- ch_mask_in  in  CH_CNT  enabled channels, latched at start and at each scan wrap.
- osr_log2_in  in  OSR_W  samples per channel = 2^osr, latched at start, clamped to OSR_MAX_LOG2.
- comparator_in  in  1  1 = input ≥ trial code (keep bit).
- sample_out / sample_out_n  out  1  sampling switch drive, complementary.
- enable_loop_out  out  1  high in CONVERT; enables the clock loop.
- dac_code_out  out  RES_BITS  trial code to the cap matrix.
- ch_sel_out  out  CH_W  analog mux select.
- busy_out  out  1  high in any state other than IDLE.
- conv_strobe_out  out  1  one-cycle pulse per completed single conversion.
- result_out  out  RES_BITS+OSR_MAX_LOG2  accumulated sum.
- result_ch_out  out  CH_W  channel of result_out.
- result_valid_out  out  1  result handshake valid.
- result_ready_in  in  1  result handshake ready.

## Operation
- States: IDLE, SETTLE (macro only), SAMPLE, CONVERT, ACCUM, OUTPUT.
- IDLE:
  - start_in=1 with a nonzero mask latches mask and osr, selects the lowest enabled channel, and goes to SETTLE (SAMPLE without the macro).
  - start_in with a zero mask is ignored.
- SETTLE: SETTLE_CYCLES cycles with sample_out=0, then SAMPLE.
- SAMPLE: SAMPLE_CYCLES cycles with sample_out=1 and dac_code_out=0, then CONVERT at bit k=RES_BITS-1.
- CONVERT: one cycle per bit.
  - dac_code_out = decided bits | (1<<k).
  - comparator_in is sampled at the end of the cycle: 1 keeps bit k, 0 clears it.
  - After k=0, go to ACCUM.
- ACCUM (1 cycle):
  - sum += final code; count++; conv_strobe_out=1.
  - If count == 2^osr, go to OUTPUT; otherwise go to SAMPLE (same channel, no settle).
- OUTPUT:
  - result_valid_out=1; result_out/result_ch_out are stable until the handshake.
  - No sampling or conversion occurs while stalled.
  - On valid & ready: clear sum/count and advance to the next enabled channel above the current one.
  - Passing the highest enabled channel is a wrap:
    - continuous_in=0: go to IDLE.
    - continuous_in=1: relatch mask/osr and start at the lowest enabled channel; a zero relatched mask goes to IDLE.
  - Every channel entry goes through SETTLE when the macro is on, including a single-channel rescan.
- Arithmetic:
  - The sum is unsigned and cannot overflow; the maximum is (2^RES_BITS-1)·2^OSR_MAX_LOG2.
  - result_out is zero-extended and is not shifted.
- start_in while busy: ignored. Mask changes mid-scan take effect only at the wrap.
- Reset values:
  - All outputs 0, except sample_out_n=1.
  - State IDLE; channel, sum and count cleared.
  - rst_in mid-operation aborts immediately on the next edge; a pending result is discarded.

## Timing
- Conversion from SAMPLE entry to ACCUM: SAMPLE_CYCLES+RES_BITS cycles.
- Latency, start accepted at edge 0, osr=0, macro off: result_valid_out rises at edge SAMPLE_CYCLES+RES_BITS+2 (16 with defaults).
- With the macro: add SETTLE_CYCLES (20 with defaults).
- Each extra oversample adds SAMPLE_CYCLES+RES_BITS+1 cycles.
- The handshake completes in the cycle valid & ready are both high. The next SETTLE/SAMPLE begins on the following edge; ready held high loses no cycles.
- All outputs are registered.

## Configuration
- ADC_SCAN_SETTLE_EN defined: the SETTLE state exists, and SETTLE_CYCLES idle cycles precede the first SAMPLE on every channel entry.
- Not defined: SETTLE is removed and channel entry goes directly to SAMPLE; SETTLE_CYCLES is unused.

## Test plan
- Single conversion: defaults, mask 0001, osr 0, comparator model for input 0xA5C -> result_out=0xA5C, result_ch_out=0, valid at edge 16 (20 with macro); one conv_strobe_out.
- Oversampling: osr=2, constant input 0x100 -> result_out=0x400 after 4 strobes.
- Oversampling clamp: osr=7 -> behaves as osr=4.
- Scan order: mask 1010, continuous 0 -> results for ch1 then ch3, then IDLE with busy_out=0.
- Scan rescan: mask 1010, continuous 1 -> ch1, ch3, ch1 ...
- Backpressure: ready low for 10 cycles after valid -> result held stable, sample_out=0, enable_loop_out=0 throughout; completes on ready.
- Reset mid-CONVERT: rst_in pulse -> next edge all outputs at reset values, sample_out_n=1, state IDLE.
- Ignored start: start with mask 0000 -> busy_out stays 0; start while busy -> no effect on result sequence.

Source files
------------

// File: rtl/adc_sar_scan_core.sv
// adc_sar_scan_core: multi-channel, oversampling binary SAR conversion controller.
// Ports:
//   clk_dig_in, rst_in        conversion clock, synchronous active-high reset
//   start_in, continuous_in   scan start (IDLE only), rescan after the last enabled channel
//   ch_mask_in, osr_log2_in   enabled channels and oversampling exponent, latched at start/wrap
//   comparator_in             1 = analog input >= trial code
//   sample_out, sample_out_n  complementary sampling switch drive
//   enable_loop_out           high while converting
//   dac_code_out, ch_sel_out  trial code to the cap matrix, analog mux select
//   busy_out, conv_strobe_out not idle, one pulse per finished single conversion
//   result_*                  accumulated per-channel sum on a valid/ready port
// Build option: define ADC_SCAN_SETTLE_EN to insert a SETTLE phase of SETTLE_CYCLES
// before the first sample on every channel entry.
module adc_sar_scan_core #(
    parameter int RES_BITS      = 12,
    parameter int CH_CNT        = 4,
    parameter int OSR_MAX_LOG2  = 4,
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 4,
    localparam int CH_W  = CH_CNT > 1 ? $clog2(CH_CNT) : 1,
    localparam int OSR_W = OSR_MAX_LOG2 > 0 ? $clog2(OSR_MAX_LOG2 + 1) : 1,
    localparam int ACC_W = RES_BITS + OSR_MAX_LOG2
) (
    input  logic                clk_dig_in,
    input  logic                rst_in,
    input  logic                start_in,
    input  logic                continuous_in,
    input  logic [CH_CNT-1:0]   ch_mask_in,
    input  logic [OSR_W-1:0]    osr_log2_in,
    input  logic                comparator_in,
    output logic                sample_out,
    output logic                sample_out_n,
    output logic                enable_loop_out,
    output logic [RES_BITS-1:0] dac_code_out,
    output logic [CH_W-1:0]     ch_sel_out,
    output logic                busy_out,
    output logic                conv_strobe_out,
    output logic [ACC_W-1:0]    result_out,
    output logic [CH_W-1:0]     result_ch_out,
    output logic                result_valid_out,
    input  logic                result_ready_in
);
    localparam int KW     = $clog2(RES_BITS);
    localparam int PH_MAX = SAMPLE_CYCLES > SETTLE_CYCLES ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int PH_W   = PH_MAX > 1 ? $clog2(PH_MAX) : 1;
    localparam int CNT_W  = OSR_MAX_LOG2 + 1;

`ifdef ADC_SCAN_SETTLE_EN
    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, CONVERT, ACCUM, OUTPUT} state_t;
    localparam state_t ENTRY = SETTLE;
`else
    typedef enum logic [2:0] {IDLE, SAMPLE, CONVERT, ACCUM, OUTPUT} state_t;
    localparam state_t ENTRY = SAMPLE;
`endif

    state_t              state;
    logic [PH_W-1:0]     ph;
    logic [KW-1:0]       k;
    logic [RES_BITS-1:0] code;
    logic [ACC_W-1:0]    sum;
    logic [CNT_W-1:0]    count;
    logic [CH_CNT-1:0]   mask;
    logic [OSR_W-1:0]    osr;
    logic [CH_W:0]       above;
    logic [CH_W:0]       first;
    logic [RES_BITS-1:0] dec;
    logic [CNT_W-1:0]    count_inc;
    logic [OSR_W-1:0]    osr_clamp;

    // Lowest enabled channel at or above 'from'; MSB flags that one was found.
    function automatic logic [CH_W:0] find(input logic [CH_CNT-1:0] m, input int from);
        logic [CH_W:0] r;
        r = '0;
        for (int i = CH_CNT - 1; i >= 0; i--)
            if (m[i] && i >= from) r = {1'b1, CH_W'(i)};
        return r;
    endfunction

    always_comb begin
        above     = find(mask, int'(ch_sel_out) + 1);
        first     = find(ch_mask_in, 0);
        // The trial bit is already in dac_code_out; keeping it or not is the whole decision.
        dec       = comparator_in ? dac_code_out : code;
        count_inc = count + CNT_W'(1);
        osr_clamp = osr_log2_in > OSR_W'(OSR_MAX_LOG2) ? OSR_W'(OSR_MAX_LOG2) : osr_log2_in;
    end

    always_ff @(posedge clk_dig_in) begin
        if (rst_in) begin
            state            <= IDLE;
            ph               <= '0;
            k                <= '0;
            code             <= '0;
            sum              <= '0;
            count            <= '0;
            mask             <= '0;
            osr              <= '0;
            sample_out       <= 1'b0;
            sample_out_n     <= 1'b1;
            enable_loop_out  <= 1'b0;
            dac_code_out     <= '0;
            ch_sel_out       <= '0;
            busy_out         <= 1'b0;
            conv_strobe_out  <= 1'b0;
            result_out       <= '0;
            result_ch_out    <= '0;
            result_valid_out <= 1'b0;
        end else begin
            conv_strobe_out <= 1'b0;
            case (state)
                IDLE: if (start_in && first[CH_W]) begin
                    mask         <= ch_mask_in;
                    osr          <= osr_clamp;
                    ch_sel_out   <= first[CH_W-1:0];
                    busy_out     <= 1'b1;
                    state        <= ENTRY;
                    ph           <= '0;
                    sample_out   <= ENTRY == SAMPLE;
                    sample_out_n <= ENTRY != SAMPLE;
                end
`ifdef ADC_SCAN_SETTLE_EN
                SETTLE: if (ph == PH_W'(SETTLE_CYCLES - 1)) begin
                    state        <= SAMPLE;
                    ph           <= '0;
                    sample_out   <= 1'b1;
                    sample_out_n <= 1'b0;
                end else begin
                    ph <= ph + PH_W'(1);
                end
`endif
                SAMPLE: if (ph == PH_W'(SAMPLE_CYCLES - 1)) begin
                    state           <= CONVERT;
                    sample_out      <= 1'b0;
                    sample_out_n    <= 1'b1;
                    enable_loop_out <= 1'b1;
                    k               <= KW'(RES_BITS - 1);
                    code            <= '0;
                    dac_code_out    <= RES_BITS'(1) << (RES_BITS - 1);
                end else begin
                    ph <= ph + PH_W'(1);
                end
                CONVERT: begin
                    code <= dec;
                    if (k == '0) begin
                        state           <= ACCUM;
                        enable_loop_out <= 1'b0;
                        dac_code_out    <= '0;
                    end else begin
                        k            <= k - KW'(1);
                        dac_code_out <= dec | (RES_BITS'(1) << (k - KW'(1)));
                    end
                end
                ACCUM: begin
                    sum             <= sum + ACC_W'(code);
                    count           <= count_inc;
                    conv_strobe_out <= 1'b1;
                    if (count_inc == (CNT_W'(1) << osr)) begin
                        state <= OUTPUT;
                    end else begin
                        state        <= SAMPLE;
                        ph           <= '0;
                        sample_out   <= 1'b1;
                        sample_out_n <= 1'b0;
                    end
                end
                OUTPUT: if (!result_valid_out) begin
                    // First OUTPUT cycle copies the finished sum into the held result register.
                    result_valid_out <= 1'b1;
                    result_out       <= sum;
                    result_ch_out    <= ch_sel_out;
                end else if (result_ready_in) begin
                    result_valid_out <= 1'b0;
                    sum              <= '0;
                    count            <= '0;
                    if (!above[CH_W] && continuous_in) begin
                        mask <= ch_mask_in;
                        osr  <= osr_clamp;
                    end
                    if (above[CH_W] || (continuous_in && first[CH_W])) begin
                        ch_sel_out   <= above[CH_W] ? above[CH_W-1:0] : first[CH_W-1:0];
                        state        <= ENTRY;
                        ph           <= '0;
                        sample_out   <= ENTRY == SAMPLE;
                        sample_out_n <= ENTRY != SAMPLE;
                    end else begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
